// File: rtl/decode_stage.sv
// RV32I decode stage: combinational multi-lane decode into a two-entry
// (main + skid) output buffer with ready/valid handshakes on both sides.
package decode_pkg;
  typedef enum logic [4:0] {
    F_IL, F_ADD, F_SUB, F_SLL, F_SLT, F_SLTU, F_XOR, F_SRL, F_SRA, F_OR, F_AND,
    F_LB, F_LH, F_LW, F_LBU, F_LHU, F_SB, F_SH, F_SW,
    F_BEQ, F_BNE, F_BLT, F_BGE, F_BLTU, F_BGEU, F_JAL, F_JALR, F_LUI, F_AUIPC
  } func_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL, CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP
  } class_t;

  typedef struct packed {
    logic       used;
    logic [4:0] sel;
  } reg_field_t;

  typedef struct packed {
    func_t      func;
    class_t     cls;
    reg_field_t rs1;
    reg_field_t rs2;
    reg_field_t rd;
    logic       has_imm;
    logic       uses_pc;
    logic [31:0] imm;
  } decode_instruction_t;
endpackage

module decode_stage #(
  parameter int WIDTH  = 32,
  parameter int LANES  = 2,
  parameter int STRICT = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [LANES*WIDTH-1:0]                  in_inst,
  input  logic [LANES-1:0]                        in_lane_valid,
  input  logic [WIDTH-1:0]                        in_pc,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output decode_pkg::decode_instruction_t [LANES-1:0] out_inst,
  output logic [LANES-1:0]                        out_lane_valid,
  output logic [LANES*WIDTH-1:0]                  out_pc,
  output logic [LANES-1:0]                        out_illegal
);
  import decode_pkg::*;

  localparam bit STRICT_EN = (STRICT != 0);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  function automatic decode_instruction_t decode_one(input logic [31:0] ins);
    decode_instruction_t d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic bad;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    d = '0;
    bad = 1'b0;
    f3 = ins[14:12];
    f7 = ins[31:25];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    imm_u = {ins[31:12], 12'd0};
    d.rs1.sel = ins[19:15];
    d.rs2.sel = ins[24:20];
    d.rd.sel  = ins[11:7];
    case (ins[6:0])
      7'h13: begin
        d.cls = CLS_ALU; d.rs1.used = 1'b1; d.rd.used = 1'b1; d.has_imm = 1'b1; d.imm = imm_i;
        case (f3)
          3'd0: d.func = F_ADD;
          3'd1: begin d.func = F_SLL; bad = STRICT_EN && (f7 != 7'h00); end
          3'd2: d.func = F_SLT;
          3'd3: d.func = F_SLTU;
          3'd4: d.func = F_XOR;
          3'd5: begin
            // Shift-immediate carries only the shamt; funct7 is consumed as the SRA select
            d.func = ins[30] ? F_SRA : F_SRL;
            d.imm  = {27'd0, ins[24:20]};
            bad = STRICT_EN && (f7 != 7'h00) && (f7 != 7'h20);
          end
          3'd6: d.func = F_OR;
          default: d.func = F_AND;
        endcase
      end
      7'h33: begin
        d.cls = CLS_ALU; d.rs1.used = 1'b1; d.rs2.used = 1'b1; d.rd.used = 1'b1;
        bad = STRICT_EN && (((f7 != 7'h00) && (f7 != 7'h20)) ||
                            ((f7 == 7'h20) && (f3 != 3'd0) && (f3 != 3'd5)));
        case (f3)
          3'd0: d.func = ins[30] ? F_SUB : F_ADD;
          3'd1: d.func = F_SLL;
          3'd2: d.func = F_SLT;
          3'd3: d.func = F_SLTU;
          3'd4: d.func = F_XOR;
          3'd5: d.func = ins[30] ? F_SRA : F_SRL;
          3'd6: d.func = F_OR;
          default: d.func = F_AND;
        endcase
      end
      7'h03: begin
        d.cls = CLS_LOAD; d.rs1.used = 1'b1; d.rd.used = 1'b1; d.has_imm = 1'b1; d.imm = imm_i;
        case (f3)
          3'd0: d.func = F_LB;
          3'd1: d.func = F_LH;
          3'd2: d.func = F_LW;
          3'd4: d.func = F_LBU;
          3'd5: d.func = F_LHU;
          default: begin d.func = F_LW; bad = STRICT_EN; end
        endcase
      end
      7'h23: begin
        d.cls = CLS_STORE; d.rs1.used = 1'b1; d.rs2.used = 1'b1; d.has_imm = 1'b1; d.imm = imm_s;
        case (f3)
          3'd0: d.func = F_SB;
          3'd1: d.func = F_SH;
          3'd2: d.func = F_SW;
          default: begin d.func = F_SW; bad = STRICT_EN; end
        endcase
      end
      7'h63: begin
        d.cls = CLS_BRANCH; d.rs1.used = 1'b1; d.rs2.used = 1'b1; d.has_imm = 1'b1;
        d.uses_pc = 1'b1; d.imm = imm_b;
        case (f3)
          3'd0: d.func = F_BEQ;
          3'd1: d.func = F_BNE;
          3'd4: d.func = F_BLT;
          3'd5: d.func = F_BGE;
          3'd6: d.func = F_BLTU;
          3'd7: d.func = F_BGEU;
          default: begin d.func = F_BEQ; bad = STRICT_EN; end
        endcase
      end
      7'h6F: begin
        d.cls = CLS_JUMP; d.func = F_JAL; d.rd.used = 1'b1; d.has_imm = 1'b1;
        d.uses_pc = 1'b1; d.imm = imm_j;
      end
      7'h67: begin
        d.cls = CLS_JUMP; d.func = F_JALR; d.rs1.used = 1'b1; d.rd.used = 1'b1;
        d.has_imm = 1'b1; d.uses_pc = 1'b1; d.imm = imm_i;
        bad = STRICT_EN && (f3 != 3'd0);
      end
      7'h37: begin
        d.cls = CLS_ALU; d.func = F_LUI; d.rd.used = 1'b1; d.has_imm = 1'b1; d.imm = imm_u;
      end
      7'h17: begin
        d.cls = CLS_ALU; d.func = F_AUIPC; d.rd.used = 1'b1; d.has_imm = 1'b1;
        d.uses_pc = 1'b1; d.imm = imm_u;
      end
      default: bad = 1'b1;
    endcase
    if (!d.rs1.used) d.rs1.sel = '0;
    if (!d.rs2.used) d.rs2.sel = '0;
    if (!d.rd.used)  d.rd.sel  = '0;
    d.rd.used = d.rd.used && (d.rd.sel != 5'd0);
    if (bad) d = '0;
    return d;
  endfunction

  // Stage p0: raw per-lane decode, then truncation after the first illegal lane
  decode_instruction_t [LANES-1:0] raw_p0, dec_p0;
  logic [LANES-1:0]                lv_p0, il_p0;
  logic [LANES*WIDTH-1:0]          pc_p0;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign raw_p0[g] = decode_one(in_inst[g*WIDTH +: 32]);
  end

  always_comb begin
    logic cut;
    cut    = 1'b0;
    dec_p0 = '0;
    lv_p0  = '0;
    il_p0  = '0;
    pc_p0  = '0;
    for (int i = 0; i < LANES; i++) begin
      pc_p0[i*WIDTH +: WIDTH] = in_pc + WIDTH'(4 * i);
      if (in_lane_valid[i] && !cut) begin
        dec_p0[i] = raw_p0[i];
        lv_p0[i]  = 1'b1;
        il_p0[i]  = (raw_p0[i].cls == CLS_ILLEGAL);
        cut       = il_p0[i];
      end
    end
  end

  // Stage p1: head (oldest) and skid entries
  state_t                          state;
  logic                            ready_q, vld_p1;
  decode_instruction_t [LANES-1:0] head_inst_p1, skid_inst_p1;
  logic [LANES-1:0]                head_lv_p1, skid_lv_p1, head_il_p1, skid_il_p1;
  logic [LANES*WIDTH-1:0]          head_pc_p1, skid_pc_p1;
  logic                            accept, retire;

  assign accept = in_valid & ready_q;
  assign retire = vld_p1 & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_EMPTY;
      ready_q      <= 1'b0;
      vld_p1       <= 1'b0;
      head_inst_p1 <= '0;
      skid_inst_p1 <= '0;
      head_lv_p1   <= '0;
      skid_lv_p1   <= '0;
      head_il_p1   <= '0;
      skid_il_p1   <= '0;
      head_pc_p1   <= '0;
      skid_pc_p1   <= '0;
    end else if (flush) begin
      state   <= S_EMPTY;
      ready_q <= 1'b1;
      vld_p1  <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          ready_q <= 1'b1;
          if (accept) begin
            head_inst_p1 <= dec_p0; head_lv_p1 <= lv_p0; head_il_p1 <= il_p0; head_pc_p1 <= pc_p0;
            state  <= S_ONE;
            vld_p1 <= 1'b1;
          end
        end
        S_ONE: begin
          if (accept && retire) begin
            head_inst_p1 <= dec_p0; head_lv_p1 <= lv_p0; head_il_p1 <= il_p0; head_pc_p1 <= pc_p0;
          end else if (accept) begin
            skid_inst_p1 <= dec_p0; skid_lv_p1 <= lv_p0; skid_il_p1 <= il_p0; skid_pc_p1 <= pc_p0;
            state   <= S_TWO;
            ready_q <= 1'b0;
          end else if (retire) begin
            state  <= S_EMPTY;
            vld_p1 <= 1'b0;
          end
        end
        default: begin
          if (retire) begin
            head_inst_p1 <= skid_inst_p1; head_lv_p1 <= skid_lv_p1;
            head_il_p1   <= skid_il_p1;   head_pc_p1 <= skid_pc_p1;
            state   <= S_ONE;
            ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign in_ready       = ready_q;
  assign out_valid      = vld_p1;
  assign out_inst       = head_inst_p1;
  assign out_pc         = head_pc_p1;
  assign out_lane_valid = head_lv_p1 & {LANES{vld_p1}};
  assign out_illegal    = head_il_p1 & {LANES{vld_p1}};
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter WIDTH, 32, instruction/PC/immediate width in bits.
REQ-002 Parameter LANES, 2, instructions decoded per bundle (1..4).
REQ-003 Parameter STRICT, 1, when 1 reserved funct7/funct3 encodings decode as illegal.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  discard all held bundles.
REQ-007 in_valid  input  1  bundle offered.
REQ-008 in_ready  output  1  stage can accept a bundle this cycle.
REQ-009 in_inst  input  LANES*WIDTH  raw instructions, lane i at bits [i*WIDTH +: WIDTH].
REQ-010 in_lane_valid  input  LANES  per-lane valid.
REQ-011 in_pc  input  WIDTH  PC of lane 0. Lane i PC is in_pc+4*i.
REQ-012 out_valid  output  1  decoded bundle presented.
REQ-013 out_ready  input  1  consumer accepts bundle.
REQ-014 out_inst  output  LANES x decode_instruction_t  decoded fields per lane.
REQ-015 out_lane_valid  output  LANES  per-lane valid after truncation.
REQ-016 out_pc  output  LANES*WIDTH  per-lane PC.
REQ-017 out_illegal  output  LANES  lane decoded as ILLEGAL class.

Function
REQ-018 Decode SHALL be combinational on input, results registered; latency exactly 1 cycle from input handshake to out_valid when the buffer is empty.
REQ-019 Buffer SHALL hold 2 entries (main + skid), state EMPTY/ONE/TWO; out_* always driven from the oldest entry.
- accept = in_valid & in_ready; release = out_valid & out_ready.
REQ-020 Transitions SHALL be as follows.
- EMPTY: ->ONE on accept.
- ONE: ->TWO on accept without release; ->EMPTY on release without accept; stay ONE on both.
- TWO: ->ONE on release; no accept possible.
REQ-021 in_ready SHALL equal (state != TWO) and SHALL depend only on registered state, with no combinational path from out_ready.
REQ-022 out_valid SHALL equal (state != EMPTY).
REQ-023 Ordering SHALL be FIFO; no bundle is dropped or duplicated under any in_valid/out_ready pattern.
REQ-024 flush SHALL force EMPTY at the next edge, overriding any simultaneous accept or release; the accepted bundle is discarded.
REQ-025 Opcodes decoded SHALL be 0x13, 0x33, 0x03, 0x23, 0x63, 0x6F, 0x67, 0x37 and 0x17.
- func, class and rs1/rs2/rd used/sel, has_imm and uses_pc use the team's standard RV32I mapping.
- Any other opcode gives class ILLEGAL and func IL.
REQ-026 rd.used SHALL be 0 when rd.sel==0, for every class.
REQ-027 The immediate SHALL sign-extend to WIDTH per format (I/S/B/J/U).
- For 0x13 with funct3==5 only, imm[10] SHALL be cleared and imm[WIDTH-1:5] zeroed (shamt only).
- Branch/load/store/JALR immediates with funct3==5 are unmodified.
REQ-028 With STRICT=1 the following SHALL be ILLEGAL.
- 0x33 with funct7 not in {0x00, 0x20}, or funct7=0x20 with funct3 not in {0, 5}.
- 0x13 shifts with imm[11:5] not in {0x00, 0x20}, or SLLI with 0x20.
- 0x03 with funct3 in {3, 6, 7}.
- 0x23 with funct3 >= 3.
- 0x63 with funct3 in {2, 3}.
- 0x67 with funct3 != 0.
REQ-029 Lanes with in_lane_valid=0 SHALL output out_lane_valid=0, out_illegal=0 and an all-zero decode.
REQ-030 Bundle truncation after an illegal lane.
- The first valid illegal lane keeps out_lane_valid=1 and out_illegal=1.
- Every higher lane SHALL have out_lane_valid=0.
REQ-031 A bundle with in_lane_valid all zero SHALL still be accepted and emitted with all lanes invalid.
REQ-032 out_pc lane i SHALL be in_pc+4*i modulo 2^WIDTH (wraps silently).

Reset
REQ-033 While rst=1 the stage SHALL be held in the reset state.
- State EMPTY, out_valid=0, in_ready=0, and all entry storage zero.
- Hence out_lane_valid=0 and out_illegal=0.
REQ-034 rst assertion SHALL take effect immediately without a clock edge, including mid-operation in state TWO.
REQ-035 in_ready SHALL rise on the first rising edge after rst deasserts.

Verification
REQ-036 Single ALU instruction.
- Stimulus: LANES=2, lane0=0x00500093 (addi x1,x0,5), lane1=0x4030D113 (srai x2,x1,3), out_ready=1.
- Response, next cycle: lane0 func ADD, imm 5, rd.used 1; lane1 func SRA, imm 3, class ALU.
REQ-037 Branch immediate preserved.
- Stimulus: lane0=0xFE20DEE3 (bge x1,x2,-4).
- Response: func BGE, imm 0xFFFFFFFC, rs1/rs2 used, rd.used 0.
REQ-038 Truncation.
- Stimulus: lane0=0x00000000, lane1=0x00500093.
- Response: lane0 out_illegal=1 with valid=1; lane1 out_lane_valid=0.
REQ-039 Backpressure.
- Stimulus: out_ready=0, in_valid=1 for 4 cycles with distinct PCs 0x100/0x108/0x110/0x118.
- Response: in_ready drops after 2 accepts.
- Then set out_ready=1: outputs emerge as 0x100 then 0x108, then 0x110 is accepted.
REQ-040 Flush in state TWO with simultaneous accept.
- Response: out_valid=0 next cycle and in_ready=1; the accepted bundle never appears.
REQ-041 Reset mid-operation.
- Stimulus: rst pulsed between edges while in state TWO.
- Response: out_valid=0 within the same cycle; in_ready=1 one edge after release.
